// File: rtl/debounce_bank_ctrl.sv
// Multi-channel debouncer sharing one sample-tick prescaler, with per-channel
// edge pulses and a round-robin valid/ack event stream fed by a one-deep pending store.

module debounce_lane #(
   parameter int STABLE_TICKS = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sample,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   logic [CW-1:0] cnt;
   logic          flip;

   // Flip on the tick whose increment would reach STABLE_TICKS.
   assign flip = tick && (sample != level) && (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= flip && !level;
         fall <= flip && level;
         if (tick) begin
            if ((sample == level) || flip) cnt <= '0;
            else                           cnt <= cnt + 1'b1;
         end
         if (flip) level <= ~level;
      end
   end
endmodule

module debounce_bank_ctrl #(
   parameter int N_CH         = 4,
   parameter int TICK_COUNT   = 99_999,
   parameter int STABLE_TICKS = 20
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       enable,
   input  logic [N_CH-1:0]                            noisy,
   output logic [N_CH-1:0]                            debounced,
   output logic [N_CH-1:0]                            p_edge,
   output logic [N_CH-1:0]                            n_edge,
   output logic                                       any_edge,
   output logic                                       event_valid,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] event_ch,
   output logic                                       event_rise,
   input  logic                                       event_ack,
   output logic                                       overrun,
   input  logic                                       clear_overrun
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int TC_W = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
   localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_COUNT);
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic            rise;
   } evt_t;

   logic [N_CH-1:0] sync_q1, sync;
   logic [TC_W-1:0] pre_cnt;
   logic            tick;
   logic [N_CH-1:0] edge_any, pend_v, pend_r, req_v, req_r, grab;
   logic [CH_W-1:0] last_grant, sel;
   logic            sel_found, slot_free, ovr_set;
   evt_t            evt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= '0;
         sync    <= '0;
      end else begin
         sync_q1 <= noisy;
         sync    <= sync_q1;
      end
   end

   assign tick = enable && (pre_cnt == TC_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 pre_cnt <= '0;
      else if (!enable || tick)  pre_cnt <= '0;
      else                       pre_cnt <= pre_cnt + 1'b1;
   end

   debounce_lane #(.STABLE_TICKS(STABLE_TICKS)) u_lane [N_CH-1:0] (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .sample (sync),
      .level  (debounced),
      .rise   (p_edge),
      .fall   (n_edge)
   );

   assign edge_any = p_edge | n_edge;
   assign any_edge = |edge_any;

   // A fresh edge is visible to the arbiter in its own cycle; a stored
   // pending entry takes priority over it for the payload type.
   assign req_v     = pend_v | edge_any;
   assign req_r     = (pend_v & pend_r) | (~pend_v & p_edge);
   assign slot_free = !event_valid || event_ack;

   always_comb begin
      int idx;
      idx       = 0;
      sel       = '0;
      sel_found = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         idx = (int'(last_grant) + 1 + k) % N_CH;
         if (!sel_found && req_v[CH_W'(idx)]) begin
            sel_found = 1'b1;
            sel       = CH_W'(idx);
         end
      end
   end

   always_comb begin
      grab = '0;
      if (slot_free && sel_found) grab[sel] = 1'b1;
   end

   // Grabbing a stored entry while a new edge lands keeps the new edge pending.
   assign ovr_set = |(edge_any & pend_v & ~grab);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_v <= '0;
         pend_r <= '0;
      end else begin
         pend_v <= (grab & pend_v & edge_any) | (~grab & (pend_v | edge_any));
         pend_r <= (edge_any & p_edge) | (~edge_any & pend_r);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         event_valid <= 1'b0;
         evt_q       <= '0;
         last_grant  <= CH_LAST;
      end else if (slot_free) begin
         event_valid <= sel_found;
         if (sel_found) begin
            evt_q.ch   <= sel;
            evt_q.rise <= req_r[sel];
            last_grant <= sel;
         end
      end
   end

   assign event_ch   = evt_q.ch;
   assign event_rise = evt_q.rise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)              overrun <= 1'b0;
      else if (ovr_set)       overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
   end
endmodule

// File: tb/tb_debounce_bank_ctrl.sv
// Directed bench for debounce_bank_ctrl: hand sequences for event timing,
// round-robin, overrun and reset, plus a table of settled level/event counts.

module tb_debounce_bank_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b1;
   logic       event_ack = 1'b0;
   logic       clear_overrun = 1'b0;
   logic [3:0] noisy = 4'b0000;
   logic [3:0] debounced, p_edge, n_edge;
   logic       any_edge, event_valid, event_rise, overrun;
   logic [1:0] event_ch;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] noisy;
      logic       en;
      int         cycles;
      logic [3:0] exp_deb;
      int         exp_events;
   } vec_t;
   vec_t vecs[8];

   debounce_bank_ctrl #(.N_CH(4), .TICK_COUNT(9), .STABLE_TICKS(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .noisy         (noisy),
      .debounced     (debounced),
      .p_edge        (p_edge),
      .n_edge        (n_edge),
      .any_edge      (any_edge),
      .event_valid   (event_valid),
      .event_ch      (event_ch),
      .event_rise    (event_rise),
      .event_ack     (event_ack),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         step();
         ok = event_valid;
      end
   endtask

   task automatic wait_deb(input int ch, input logic val, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         step();
         ok = (debounced[ch] == val);
      end
   endtask

   initial begin
      bit ok, stable, bad;
      int n, cnt;

      vecs[0] = '{4'b1000, 1'b1, 40, 4'b1000, 2};
      vecs[1] = '{4'b0000, 1'b0, 40, 4'b1000, 0};
      vecs[2] = '{4'b0000, 1'b1, 40, 4'b0000, 1};
      vecs[3] = '{4'b0110, 1'b1, 40, 4'b0110, 2};
      vecs[4] = '{4'b0110, 1'b1,  5, 4'b0110, 0};
      vecs[5] = '{4'b1111, 1'b0, 30, 4'b0110, 0};
      vecs[6] = '{4'b1111, 1'b1, 40, 4'b1111, 2};
      vecs[7] = '{4'b0000, 1'b1, 40, 4'b0000, 4};

      // Reset state
      #2 reset = 1'b1;
      step(3);
      check("rst_deb",   32'(debounced), 0);
      check("rst_edges", 32'({p_edge, n_edge, any_edge}), 0);
      check("rst_event", 32'({event_valid, event_ch, event_rise}), 0);
      check("rst_ovr",   32'(overrun), 0);
      reset = 1'b0;
      step(2);

      // Round-robin: simultaneous rises on 0, 2, 3 held unacked
      noisy = 4'b1101;
      wait_valid(45, ok);
      check("rr_first_seen", 32'(ok), 1);
      check("rr_first", 32'({event_ch, event_rise}), 32'({2'd0, 1'b1}));
      check("rr_deb", 32'(debounced), 32'(4'b1101));
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         stable &= event_valid && (event_ch == 2'd0) && event_rise;
      end
      check("rr_hold", 32'(stable), 1);
      event_ack = 1'b1;
      step();
      event_ack = 1'b0;
      check("rr_second", 32'({event_valid, event_ch, event_rise}), 32'({1'b1, 2'd2, 1'b1}));
      step(2);
      check("rr_second_hold", 32'({event_valid, event_ch}), 32'({1'b1, 2'd2}));
      event_ack = 1'b1;
      step();
      check("rr_third", 32'({event_valid, event_ch}), 32'({1'b1, 2'd3}));
      step();
      check("rr_drain", 32'(event_valid), 0);

      // Back-to-back with ack held: falls on 0, 2, 3
      noisy = 4'b0000;
      wait_valid(45, ok);
      check("b2b_seen", 32'(ok), 1);
      check("b2b_0", 32'({event_ch, event_rise}), 32'({2'd0, 1'b0}));
      step();
      check("b2b_1", 32'({event_valid, event_ch}), 32'({1'b1, 2'd2}));
      step();
      check("b2b_2", 32'({event_valid, event_ch}), 32'({1'b1, 2'd3}));
      step();
      check("b2b_end", 32'(event_valid), 0);
      event_ack = 1'b0;

      // Clean rise on channel 0
      noisy[0] = 1'b1;
      n = 0;
      ok = 1'b0;
      while (n < 40 && !ok) begin
         step();
         n++;
         ok = debounced[0];
      end
      check("rise_latency", 32'(ok && n <= 33), 1);
      check("rise_pedge", 32'({p_edge, n_edge, any_edge}), 32'({4'b0001, 4'b0000, 1'b1}));
      check("rise_pre_valid", 32'(event_valid), 0);
      step();
      check("rise_pedge_width", 32'(p_edge), 0);
      check("rise_event", 32'({event_valid, event_ch, event_rise}), 32'({1'b1, 2'd0, 1'b1}));
      event_ack = 1'b1;
      step();
      event_ack = 1'b0;
      check("rise_acked", 32'(event_valid), 0);

      // Bounce on channel 1: toggle every 7 cycles for 60 cycles
      bad = 1'b0;
      for (int c = 0; c < 60; c++) begin
         noisy[1] = ((c / 7) % 2) == 0;
         step();
         if (debounced[1] || event_valid) bad = 1'b1;
      end
      check("bounce_quiet", 32'(bad), 0);
      noisy[1] = 1'b1;
      wait_deb(1, 1'b1, ok);
      check("bounce_settle", 32'(ok), 1);
      step();
      check("bounce_event", 32'({event_valid, event_ch, event_rise}), 32'({1'b1, 2'd1, 1'b1}));
      event_ack = 1'b1;
      step();
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (event_valid) cnt++;
      end
      check("bounce_single", 32'(cnt), 0);
      event_ack = 1'b0;

      // Overrun: ch2 rises then falls while a ch0 event is held
      noisy[0] = 1'b0;
      wait_valid(45, ok);
      check("ovr_ch0_seen", 32'({ok, event_ch, event_rise}), 32'({1'b1, 2'd0, 1'b0}));
      noisy[2] = 1'b1;
      wait_deb(2, 1'b1, ok);
      check("ovr_ch2_up", 32'(ok), 1);
      noisy[2] = 1'b0;
      wait_deb(2, 1'b0, ok);
      check("ovr_ch2_down", 32'(ok), 1);
      step(2);
      check("ovr_flag", 32'(overrun), 1);
      check("ovr_ch0_held", 32'({event_valid, event_ch}), 32'({1'b1, 2'd0}));
      event_ack = 1'b1;
      step();
      event_ack = 1'b0;
      check("ovr_ch2_event", 32'({event_valid, event_ch, event_rise}), 32'({1'b1, 2'd2, 1'b0}));
      event_ack = 1'b1;
      step();
      event_ack = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (event_valid) cnt++;
      end
      check("ovr_ch2_once", 32'(cnt), 0);
      check("ovr_sticky", 32'(overrun), 1);
      clear_overrun = 1'b1;
      step();
      clear_overrun = 1'b0;
      check("ovr_cleared", 32'(overrun), 0);

      // Table: settled levels and event counts with ack held high
      event_ack = 1'b1;
      foreach (vecs[v]) begin
         noisy  = vecs[v].noisy;
         enable = vecs[v].en;
         cnt = 0;
         for (int c = 0; c < vecs[v].cycles; c++) begin
            step();
            if (event_valid) cnt++;
         end
         check($sformatf("vec%0d_deb", v), 32'(debounced), 32'(vecs[v].exp_deb));
         check($sformatf("vec%0d_events", v), 32'(cnt), 32'(vecs[v].exp_events));
         check($sformatf("vec%0d_idle", v), 32'(event_valid), 0);
      end
      enable = 1'b1;
      event_ack = 1'b0;

      // Reset with an event presented
      noisy = 4'b0001;
      wait_valid(45, ok);
      check("rst_mid_seen", 32'({ok, event_ch, event_rise}), 32'({1'b1, 2'd0, 1'b1}));
      #2 reset = 1'b1;
      noisy = 4'b0000;
      #1;
      check("rst_mid_deb",   32'(debounced), 0);
      check("rst_mid_event", 32'({event_valid, event_ch, event_rise}), 0);
      check("rst_mid_edges", 32'({p_edge, n_edge, any_edge, overrun}), 0);
      step(3);
      reset = 1'b0;
      event_ack = 1'b1;
      cnt = 0;
      for (int i = 0; i < 45; i++) begin
         step();
         if (event_valid || debounced != 4'b0000) cnt++;
      end
      check("rst_mid_no_stale", 32'(cnt), 0);
      event_ack = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/debounce_bank_ctrl.md
# debounce_bank_ctrl

Multi-channel debounce controller that shares one sample-tick timebase among `N_CH` noisy inputs, such as push-buttons and switches. It delivers per-channel debounced levels and edge pulses. It also serialises all edge events into a single valid/ack event stream with round-robin fairness. It sits between the board I/O pins and the UART command/control logic, and replaces one private timer per input.

## Interface
Parameters:
- `N_CH`, 4: number of input channels (1..16).
- `TICK_COUNT`, 99_999: prescaler terminal count; one sample tick every `TICK_COUNT+1` clocks (1 ms at 100 MHz).
- `STABLE_TICKS`, 20: consecutive differing samples required to flip a channel (>=1).

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `enable`, input, 1: 0 holds the prescaler at 0 and freezes all channel counters.
- `noisy`, input, N_CH: raw asynchronous inputs.
- `debounced`, output, N_CH: filtered levels.
- `p_edge`, output, N_CH: one-cycle pulse on a 0->1 debounced transition.
- `n_edge`, output, N_CH: one-cycle pulse on a 1->0 debounced transition.
- `any_edge`, output, 1: OR of all `p_edge` and `n_edge` bits.
- `event_valid`, output, 1: an event is presented.
- `event_ch`, output, clog2(N_CH) (min 1): channel of the presented event.
- `event_rise`, output, 1: 1 for a rising event, 0 for a falling event.
- `event_ack`, input, 1: consumer accepts the event; it is meaningful only while `event_valid` is high.
- `overrun`, output, 1: sticky flag; a channel's pending event was overwritten before it was presented.
- `clear_overrun`, input, 1: synchronous clear of `overrun`.

## Operation
- **Synchroniser:** each `noisy` bit passes through a 2-flop synchroniser (`sync`). Synchroniser flops reset to 0.
- **Prescaler:** `tick` is high for one cycle when the count equals `TICK_COUNT`; the count then wraps to 0. The count stays at 0 while `enable` is 0.
- **Channel filter:** each channel has a counter of width clog2(STABLE_TICKS+1). On a tick:
  - If `sync[i] != debounced[i]`, the counter increments.
  - When the incremented value equals `STABLE_TICKS`, `debounced[i]` toggles and the counter clears.
  - If `sync[i] == debounced[i]`, the counter clears.
  - Between ticks the counter holds.
- **Edge pulses:** `p_edge[i]` / `n_edge[i]` is high exactly in the first cycle `debounced[i]` shows its new value.
- **Pending store:** each channel has a `pend_v` bit and a `pend_r` type bit. An edge sets `pend_v` and writes `pend_r` to the edge type. If `pend_v` was already set, the type is overwritten and `overrun` is set.
- **Arbiter:** loads the output registers when the output slot is free, i.e. `event_valid` is 0, or `event_valid` and `event_ack` are both 1 in this cycle.
  - Selection is the first channel with `pend_v` set, searching round-robin from `last_grant+1` modulo `N_CH`.
  - Loading sets `event_valid`, `event_ch`, `event_rise` and `last_grant`, and clears that channel's `pend_v`.
  - If nothing is pending, `event_valid` goes to 0.
- **Simultaneous edge and grab:** if a channel's edge arrives in the same cycle the arbiter grabs that channel, the grabbed payload uses the old type. The new edge leaves `pend_v` set with the new type and does not set `overrun`.
- **Payload stability:** `event_ch` and `event_rise` stay constant while `event_valid` is high and `event_ack` is low.
- **Overrun clear:** if `clear_overrun` and a new overrun occur in the same cycle, set wins.
- **Reset values:** all outputs are 0 and `last_grant` is `N_CH-1`, so the first search starts at channel 0. An input held high through reset release produces a rising event after filtering.
- **Reset mid-operation:** discards pending and presented events immediately; no partial state survives.

## Timing
- **Input latency:** a `noisy` change is visible on `sync` 2 cycles later.
- **Debounce latency:** `debounced` flips 1 cycle after the tick that takes the `STABLE_TICKS`-th consecutive differing sample.
- **Event latency:** with no competing events, `event_valid` rises 1 cycle after the edge-pulse cycle.
- **Back-to-back throughput:** an ack in cycle A with another event pending gives `event_valid` high in A+1 with the new payload, so the stream sustains 1 event/cycle.
- **Glitch rejection:** a glitch shorter than one tick period that lands between ticks is ignored. One that is sampled on fewer than `STABLE_TICKS` consecutive ticks only resets the counter.

## Test plan
Bench configuration: `N_CH`=4, `TICK_COUNT`=9, `STABLE_TICKS`=3.
- **Clean rise:** `noisy[0]` steps 0->1 and is held.
  - `debounced[0]`=1 within 33 cycles.
  - `p_edge[0]` is one cycle wide.
  - `event_valid`=1 with `ch`=0 and `rise`=1 the next cycle.
  - Ack it; `event_valid`=0 afterwards.
- **Bounce:** `noisy[1]` toggles every 7 cycles for 60 cycles, then holds 1.
  - No `debounced[1]` change during the toggling.
  - Exactly one rising event after it settles.
- **Round-robin:** rises on channels 0, 2 and 3 become pending while `event_ack`=0.
  - Events appear in order ch0, ch2, ch3.
  - Payload is stable until ack.
  - With `ack` held high, the three events go out on consecutive cycles.
- **Overrun:** channel 2 rises then falls while a ch0 event is held unacked.
  - `overrun`=1.
  - ch2 is presented once, with `rise`=0.
  - `clear_overrun` clears the flag.
- **Enable/reset:**
  - `enable`=0 while `noisy[3]` changes: no tick, `debounced` frozen. Re-enable and the change completes.
  - Assert `reset` with an event presented: all outputs are 0 at once, and no stale event appears after release.
